// File: rtl/rv_pkg.sv
// Shared write-back types and default widths for the register-file write path.
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG_W = 5;

    typedef struct packed {
        logic [NREG_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding slot for a write-back source; drains when granted by the arbiter.
module wb_hold_slot #(
    parameter int unsigned XLEN   = rv_pkg::XLEN,
    parameter int unsigned NREG_W = rv_pkg::NREG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    output logic              ready,
    input  logic [NREG_W-1:0] rd,
    input  logic [XLEN-1:0]   data,
    input  logic              grant,
    output logic              hold_v,
    output logic [NREG_W-1:0] hold_rd,
    output logic [XLEN-1:0]   hold_data
);

    logic load;

    // A slot being drained this cycle may be refilled on the same edge.
    assign ready = !hold_v || grant;
    // Writes to x0 are accepted but never occupy the slot.
    assign load  = valid && ready && (rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v    <= 1'b0;
            hold_rd   <= '0;
            hold_data <= '0;
        end else if (load) begin
            hold_v    <= 1'b1;
            hold_rd   <= rd;
            hold_data <= data;
        end else if (grant) begin
            hold_v    <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter merging ALU and load-unit write-backs onto one register-file write port,
// with scoreboard-style pending lookup for the decode stage.
module reg_wb_arbiter #(
    parameter int unsigned XLEN   = rv_pkg::XLEN,
    parameter int unsigned NREG_W = rv_pkg::NREG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [NREG_W-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [NREG_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              write_enable,
    output logic [NREG_W-1:0] write_reg,
    output logic [XLEN-1:0]   write_data,
    input  logic [NREG_W-1:0] query_reg1,
    input  logic [NREG_W-1:0] query_reg2,
    output logic              pending1,
    output logic              pending2
);

    import rv_pkg::*;

    logic              alu_hv, lsu_hv;
    logic [NREG_W-1:0] alu_hrd, lsu_hrd;
    logic [XLEN-1:0]   alu_hdata, lsu_hdata;
    logic              grant_alu, grant_lsu;
    wb_src_e           rr_last;

    wb_hold_slot #(.XLEN(XLEN), .NREG_W(NREG_W)) u_alu_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (alu_valid),
        .ready     (alu_ready),
        .rd        (alu_rd),
        .data      (alu_data),
        .grant     (grant_alu),
        .hold_v    (alu_hv),
        .hold_rd   (alu_hrd),
        .hold_data (alu_hdata)
    );

    wb_hold_slot #(.XLEN(XLEN), .NREG_W(NREG_W)) u_lsu_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (lsu_valid),
        .ready     (lsu_ready),
        .rd        (lsu_rd),
        .data      (lsu_data),
        .grant     (grant_lsu),
        .hold_v    (lsu_hv),
        .hold_rd   (lsu_hrd),
        .hold_data (lsu_hdata)
    );

    // On a tie the source that lost last time wins.
    always_comb begin
        grant_alu = alu_hv && (!lsu_hv || (rr_last == SRC_LSU));
        grant_lsu = lsu_hv && !grant_alu;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last      <= SRC_LSU;
            write_enable <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= grant_alu || grant_lsu;
            if (grant_alu) begin
                rr_last    <= SRC_ALU;
                write_reg  <= alu_hrd;
                write_data <= alu_hdata;
            end else if (grant_lsu) begin
                rr_last    <= SRC_LSU;
                write_reg  <= lsu_hrd;
                write_data <= lsu_hdata;
            end
        end
    end

    always_comb begin
        pending1 = (query_reg1 != '0) &&
                   ((alu_hv && (alu_hrd == query_reg1)) ||
                    (lsu_hv && (lsu_hrd == query_reg1)) ||
                    (write_enable && (write_reg == query_reg1)));
        pending2 = (query_reg2 != '0) &&
                   ((alu_hv && (alu_hrd == query_reg2)) ||
                    (lsu_hv && (lsu_hrd == query_reg2)) ||
                    (write_enable && (write_reg == query_reg2)));
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter.
module tb_reg_wb_arbiter;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG_W = 5;

    logic              clk;
    logic              rst_n;
    logic              alu_valid, alu_ready;
    logic [NREG_W-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              lsu_valid, lsu_ready;
    logic [NREG_W-1:0] lsu_rd;
    logic [XLEN-1:0]   lsu_data;
    logic              write_enable;
    logic [NREG_W-1:0] write_reg;
    logic [XLEN-1:0]   write_data;
    logic [NREG_W-1:0] query_reg1, query_reg2;
    logic              pending1, pending2;

    int n_tests;
    int n_fail;

    reg_wb_arbiter #(.XLEN(XLEN), .NREG_W(NREG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .query_reg1   (query_reg1),
        .query_reg2   (query_reg2),
        .pending1     (pending1),
        .pending2     (pending2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [NREG_W+XLEN-1:0] wq[$];
    logic [NREG_W+XLEN-1:0] exp_w;
    logic                   afire, lfire;
    int                     ai, li, first_wc, last_wc, n7;
    logic [XLEN-1:0]        last7;
    logic                   saw_we;

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        alu_valid  = 1'b1;
        alu_rd     = 5'd3;
        alu_data   = 32'hDEAD;
        lsu_valid  = 1'b0;
        lsu_rd     = '0;
        lsu_data   = '0;
        query_reg1 = 5'd3;
        query_reg2 = '0;

        // Reset behaviour with a request offered while held in reset.
        tick;
        tick;
        check_eq("rst_alu_ready", alu_ready, 1'b1);
        check_eq("rst_lsu_ready", lsu_ready, 1'b1);
        check_eq("rst_we", write_enable, 1'b0);
        check_eq("rst_wreg", write_reg, 5'd0);
        check_eq("rst_wdata", write_data, 32'd0);
        check_eq("rst_pending1", pending1, 1'b0);
        alu_valid = 1'b0;
        rst_n     = 1'b1;
        tick;
        check_eq("post_rst_pending1", pending1, 1'b0);
        tick;
        check_eq("post_rst_we", write_enable, 1'b0);

        // Uncontended ALU write: two-cycle latency.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234; query_reg1 = 5'd5;
        tick;
        alu_valid = 1'b0;
        #1;
        check_eq("c1_we", write_enable, 1'b0);
        check_eq("c1_pending1", pending1, 1'b1);
        tick;
        check_eq("c2_we", write_enable, 1'b1);
        check_eq("c2_wreg", write_reg, 5'd5);
        check_eq("c2_wdata", write_data, 32'h1234);
        check_eq("c2_pending1", pending1, 1'b1);
        tick;
        check_eq("c3_we", write_enable, 1'b0);
        check_eq("c3_pending1", pending1, 1'b0);
        check_eq("c3_wreg_hold", write_reg, 5'd5);
        check_eq("c3_wdata_hold", write_data, 32'h1234);

        // Tie right after reset goes to ALU first.
        pulse_reset;
        tick;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB;
        #1;
        check_eq("tie_c0_lsu_ready", lsu_ready, 1'b1);
        tick;
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        check_eq("tie_c1_lsu_ready", lsu_ready, 1'b0);
        check_eq("tie_c1_alu_ready", alu_ready, 1'b1);
        tick;
        check_eq("tie_c2_we", write_enable, 1'b1);
        check_eq("tie_c2_wreg", write_reg, 5'd1);
        check_eq("tie_c2_wdata", write_data, 32'hA);
        check_eq("tie_c2_lsu_ready", lsu_ready, 1'b1);
        tick;
        check_eq("tie_c3_we", write_enable, 1'b1);
        check_eq("tie_c3_wreg", write_reg, 5'd2);
        check_eq("tie_c3_wdata", write_data, 32'hB);
        tick;
        check_eq("tie_c4_we", write_enable, 1'b0);

        // Both sources streaming 8 requests each; last grant was LSU so ALU leads.
        ai = 0; li = 0; first_wc = -1; last_wc = -1;
        wq.delete();
        for (int cyc = 0; cyc < 40; cyc++) begin
            alu_valid = (ai < 8);
            alu_rd    = 5'(1 + ai);
            alu_data  = 32'h100 + 32'(ai);
            lsu_valid = (li < 8);
            lsu_rd    = 5'(9 + li);
            lsu_data  = 32'h200 + 32'(li);
            #1;
            afire = alu_valid && alu_ready;
            lfire = lsu_valid && lsu_ready;
            if (write_enable) begin
                wq.push_back({write_reg, write_data});
                if (first_wc < 0) first_wc = cyc;
                last_wc = cyc;
            end
            tick;
            if (afire) ai++;
            if (lfire) li++;
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        check_eq("stream_count", wq.size(), 16);
        check_eq("stream_span", last_wc - first_wc, 15);
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) exp_w = {5'(1 + k / 2), 32'h100 + 32'(k / 2)};
            else            exp_w = {5'(9 + k / 2), 32'h200 + 32'(k / 2)};
            if (k < wq.size()) check_eq($sformatf("stream_w%0d", k), wq[k], exp_w);
            else               check_eq($sformatf("stream_w%0d_missing", k), 1'b0, 1'b1);
        end

        // Write to x0 is swallowed.
        tick;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF; query_reg1 = 5'd0;
        #1;
        check_eq("x0_ready", alu_ready, 1'b1);
        tick;
        alu_valid = 1'b0;
        saw_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (write_enable || pending1 || !alu_ready) saw_we = 1'b1;
            tick;
        end
        check_eq("x0_no_effect", saw_we, 1'b0);

        // Same destination from both sources: later grant's data is final.
        query_reg2 = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1;
        tick;
        alu_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h2;
        #1;
        check_eq("same_rd_pending2", pending2, 1'b1);
        n7 = 0; last7 = '0;
        tick;
        lsu_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (write_enable && write_reg == 5'd7) begin
                n7++;
                last7 = write_data;
            end
            tick;
        end
        check_eq("same_rd_count", n7, 2);
        check_eq("same_rd_last", last7, 32'h2);

        // Reset mid-cycle with a write in flight and a slot full.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        query_reg1 = 5'd4;
        tick;
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick;
        check_eq("mid_pre_we", write_enable, 1'b1);
        check_eq("mid_pre_pending1", pending1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_we", write_enable, 1'b0);
        check_eq("mid_rst_wreg", write_reg, 5'd0);
        check_eq("mid_rst_wdata", write_data, 32'd0);
        check_eq("mid_rst_pending1", pending1, 1'b0);
        check_eq("mid_rst_lsu_ready", lsu_ready, 1'b1);
        #1;
        rst_n = 1'b1;
        saw_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (write_enable) saw_we = 1'b1;
        end
        check_eq("mid_no_write_after", saw_we, 1'b0);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55;
        tick;
        alu_valid = 1'b0;
        #1;
        check_eq("mid_new_c1_we", write_enable, 1'b0);
        tick;
        check_eq("mid_new_c2_we", write_enable, 1'b1);
        check_eq("mid_new_c2_wreg", write_reg, 5'd9);
        check_eq("mid_new_c2_wdata", write_data, 32'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
